// File: rtl/rename_status_file_if.sv
// Decode/ROB-facing bundle of the rename status file. The DUT uses the
// slave modport; whoever drives lookups, dispatch, commit and checkpoint
// control uses the master modport.
interface rename_status_file_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int ROB_W = 4,
    parameter int CK_W  = 2
);
    logic             rdy;
    logic [REG_W-1:0] q1_reg, q2_reg;
    logic [XLEN-1:0]  q1_value, q2_value;
    logic [ROB_W-1:0] q1_tag, q2_tag;
    logic             q1_busy, q2_busy;
    logic             disp_valid;
    logic [REG_W-1:0] disp_rd;
    logic [ROB_W-1:0] disp_rob;
    logic             cm0_valid, cm1_valid;
    logic [REG_W-1:0] cm0_reg, cm1_reg;
    logic [ROB_W-1:0] cm0_rob, cm1_rob;
    logic [XLEN-1:0]  cm0_value, cm1_value;
    logic             ck_save;
    logic [CK_W-1:0]  ck_id;
    logic             ck_full;
    logic             rs_valid, rs_mispredict;
    logic [CK_W-1:0]  rs_id;
    logic             flush;

    modport master (
        output rdy, q1_reg, q2_reg, disp_valid, disp_rd, disp_rob,
               cm0_valid, cm1_valid, cm0_reg, cm1_reg, cm0_rob, cm1_rob,
               cm0_value, cm1_value, ck_save, rs_valid, rs_mispredict, rs_id, flush,
        input  q1_value, q2_value, q1_tag, q2_tag, q1_busy, q2_busy, ck_id, ck_full
    );

    modport slave (
        input  rdy, q1_reg, q2_reg, disp_valid, disp_rd, disp_rob,
               cm0_valid, cm1_valid, cm0_reg, cm1_reg, cm0_rob, cm1_rob,
               cm0_value, cm1_value, ck_save, rs_valid, rs_mispredict, rs_id, flush,
        output q1_value, q2_value, q1_tag, q2_tag, q1_busy, q2_busy, ck_id, ck_full
    );
endinterface

// File: rtl/rename_status_file.sv
// Architectural register file plus rename-status table with branch
// checkpoints. Lookups are combinational with commit forwarding; every
// state update lands on the clock edge. Values are never checkpointed,
// only tags/busy, so a mispredict rolls back renames but keeps retired data.
module rename_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int REG_W = 5,
    parameter int ROB_W = 4,
    parameter int NCKPT = 4,
    parameter int CK_W  = 2
) (
    input logic                clk,
    input logic                rst,
    rename_status_file_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [ROB_W-1:0] tag;
        logic             busy;
    } lookup_t;

    logic [XLEN-1:0]  values_q [NREG];
    logic [XLEN-1:0]  values_d [NREG];
    logic [ROB_W-1:0] tags_q   [NREG];
    logic [ROB_W-1:0] tags_d   [NREG];
    logic [NREG-1:0]  busy_q, busy_d, busy_c;
    logic [ROB_W-1:0] ck_tags_q [NCKPT][NREG];
    logic [ROB_W-1:0] ck_tags_d [NCKPT][NREG];
    logic [NREG-1:0]  ck_busy_q [NCKPT];
    logic [NREG-1:0]  ck_busy_d [NCKPT];
    logic [NREG-1:0]  ck_busy_c [NCKPT];
    logic [NCKPT-1:0] ck_valid_q, ck_valid_d;
    logic [CK_W-1:0]  tail_q, tail_d;

    // Commit ports gathered into arrays; index 1 is younger and wins ties.
    logic             cm_valid [2];
    logic [REG_W-1:0] cm_reg   [2];
    logic [ROB_W-1:0] cm_rob   [2];
    logic [XLEN-1:0]  cm_value [2];

    assign cm_valid[0] = bus.cm0_valid;
    assign cm_valid[1] = bus.cm1_valid;
    assign cm_reg[0]   = bus.cm0_reg;
    assign cm_reg[1]   = bus.cm1_reg;
    assign cm_rob[0]   = bus.cm0_rob;
    assign cm_rob[1]   = bus.cm1_rob;
    assign cm_value[0] = bus.cm0_value;
    assign cm_value[1] = bus.cm1_value;

    logic mispredict;
    assign mispredict = bus.rs_valid && bus.rs_mispredict && ck_valid_q[bus.rs_id];

    assign bus.ck_id   = tail_q;
    assign bus.ck_full = ck_valid_q[tail_q];

    function automatic lookup_t lookup(input logic [REG_W-1:0] r);
        lookup_t o;
        o.value = values_q[r];
        o.tag   = tags_q[r];
        o.busy  = busy_q[r];
        for (int p = 0; p < 2; p++) begin
            if (cm_valid[p] && cm_reg[p] == r && busy_q[r] && tags_q[r] == cm_rob[p]) begin
                o.busy  = 1'b0;
                o.value = cm_value[p];
            end
        end
        if (r == '0) o = '0;
        return o;
    endfunction

    lookup_t q1, q2;

    // Source-operand lookups with same-cycle commit forwarding.
    always_comb begin
        q1 = lookup(bus.q1_reg);
        q2 = lookup(bus.q2_reg);
    end

    assign bus.q1_value = q1.value;
    assign bus.q1_tag   = q1.tag;
    assign bus.q1_busy  = q1.busy;
    assign bus.q2_value = q2.value;
    assign bus.q2_tag   = q2.tag;
    assign bus.q2_busy  = q2.busy;

    // Commit effects: values, live busy bits and busy bits in every valid snapshot.
    always_comb begin
        values_d  = values_q;
        busy_c    = busy_q;
        ck_busy_c = ck_busy_q;
        for (int p = 0; p < 2; p++) begin
            if (cm_valid[p] && cm_reg[p] != '0) begin
                values_d[cm_reg[p]] = cm_value[p];
                if (tags_q[cm_reg[p]] == cm_rob[p]) busy_c[cm_reg[p]] = 1'b0;
                for (int k = 0; k < NCKPT; k++) begin
                    if (ck_valid_q[k] && ck_tags_q[k][cm_reg[p]] == cm_rob[p])
                        ck_busy_c[k][cm_reg[p]] = 1'b0;
                end
            end
        end
    end

    // Rename/checkpoint next state: flush > mispredict > {dispatch, save, resolve}.
    always_comb begin
        logic [CK_W-1:0] span;
        logic [CK_W-1:0] offs;
        tags_d     = tags_q;
        busy_d     = busy_c;
        ck_tags_d  = ck_tags_q;
        ck_busy_d  = ck_busy_c;
        ck_valid_d = ck_valid_q;
        tail_d     = tail_q;
        span       = tail_q - bus.rs_id;
        offs       = '0;
        if (bus.flush) begin
            tags_d     = '{default: '0};
            busy_d     = '0;
            ck_valid_d = '0;
            tail_d     = '0;
        end else if (mispredict) begin
            tags_d = ck_tags_q[bus.rs_id];
            busy_d = ck_busy_c[bus.rs_id];
            // Free rs_id and everything younger up to tail-1. span == 0 with a
            // valid rs_id means the ring is full, so every slot is younger.
            for (int k = 0; k < NCKPT; k++) begin
                offs = CK_W'(k) - bus.rs_id;
                if (offs < span || span == '0) ck_valid_d[k] = 1'b0;
            end
            tail_d = bus.rs_id;
        end else begin
            if (bus.disp_valid && bus.disp_rd != '0) begin
                busy_d[bus.disp_rd] = 1'b1;
                tags_d[bus.disp_rd] = bus.disp_rob;
            end
            if (bus.rs_valid && !bus.rs_mispredict && ck_valid_q[bus.rs_id])
                ck_valid_d[bus.rs_id] = 1'b0;
            // Snapshot sees this cycle's commits and dispatch.
            if (bus.ck_save && !ck_valid_q[tail_q]) begin
                ck_tags_d[tail_q]  = tags_d;
                ck_busy_d[tail_q]  = busy_d;
                ck_valid_d[tail_q] = 1'b1;
                tail_d             = tail_q + CK_W'(1);
            end
        end
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            values_q   <= '{default: '0};
            tags_q     <= '{default: '0};
            busy_q     <= '0;
            ck_tags_q  <= '{default: '0};
            ck_busy_q  <= '{default: '0};
            ck_valid_q <= '0;
            tail_q     <= '0;
        end else if (bus.rdy) begin
            values_q   <= values_d;
            tags_q     <= tags_d;
            busy_q     <= busy_d;
            ck_tags_q  <= ck_tags_d;
            ck_busy_q  <= ck_busy_d;
            ck_valid_q <= ck_valid_d;
            tail_q     <= tail_d;
        end
    end
endmodule
